// File: rtl/imem_loader.sv
// Instruction memory loader: assembles big-endian words from a byte stream and
// writes them to consecutive word addresses while holding the core stalled.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_count,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_r;
  state_t              next_state_s;
  logic [ADDR_W:0]     count_r;
  logic [ADDR_W:0]     word_idx_r;
  logic [1:0]          byte_cnt_r;
  logic [31:0]         word_buf_r;
  logic                in_ready_r;
  logic                core_hold_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [31:0]         mem_wdata_r;
  logic                load_error_r;
  logic [31:0]         checksum_r;

  logic                count_ok_s;
  logic                start_ok_s;
  logic                start_bad_s;
  logic                accept_s;
  logic                last_byte_s;
  logic                write_ok_s;
  logic                last_word_s;
  logic                abort_act_s;

  assign count_ok_s  = (load_count != {(ADDR_W+1){1'b0}}) && (load_count <= DEPTH_C);
  assign start_ok_s  = (state_r == IDLE) && load_start && count_ok_s;
  assign start_bad_s = (state_r == IDLE) && load_start && !count_ok_s;
  // abort wins over a same-cycle byte accept, so the accept is gated here
  assign abort_act_s = (state_r != IDLE) && abort;
  assign accept_s    = (state_r == RECV) && in_valid && !abort;
  assign last_byte_s = accept_s && (byte_cnt_r == 2'd3);
  assign write_ok_s  = (state_r == WRITE) && !abort;
  assign last_word_s = ((word_idx_r + ONE_C) == count_r);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) next_state_s = RECV;
        else            next_state_s = IDLE;
      end
      RECV: begin
        if (abort)            next_state_s = IDLE;
        else if (last_byte_s) next_state_s = WRITE;
        else                  next_state_s = RECV;
      end
      WRITE: begin
        if (abort)            next_state_s = IDLE;
        else if (last_word_s) next_state_s = DONE;
        else                  next_state_s = RECV;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Handshake and stall outputs follow the state being entered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_ready_r  <= 1'b0;
      core_hold_r <= 1'b0;
    end else begin
      in_ready_r  <= (next_state_s == RECV);
      core_hold_r <= (next_state_s != IDLE);
    end
  end

  // Load bookkeeping: count, error flag, checksum and word index
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r      <= {(ADDR_W+1){1'b0}};
      word_idx_r   <= {(ADDR_W+1){1'b0}};
      load_error_r <= 1'b0;
      checksum_r   <= 32'h0000_0000;
    end else if (start_ok_s) begin
      count_r      <= load_count;
      word_idx_r   <= {(ADDR_W+1){1'b0}};
      load_error_r <= 1'b0;
      checksum_r   <= 32'h0000_0000;
    end else if (start_bad_s || abort_act_s) begin
      load_error_r <= 1'b1;
    end else if (write_ok_s) begin
      checksum_r <= checksum_r ^ word_buf_r;
      if (!last_word_s) word_idx_r <= word_idx_r + ONE_C;
      else              word_idx_r <= word_idx_r;
    end else begin
      count_r <= count_r;
    end
  end

  // Byte assembly; the write address/data are captured with the final byte
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt_r  <= 2'd0;
      word_buf_r  <= 32'h0000_0000;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= 32'h0000_0000;
    end else if (start_ok_s) begin
      byte_cnt_r <= 2'd0;
      word_buf_r <= 32'h0000_0000;
    end else if (accept_s) begin
      byte_cnt_r <= byte_cnt_r + 2'd1;
      word_buf_r <= {word_buf_r[23:0], in_data};
      if (last_byte_s) begin
        mem_addr_r  <= word_idx_r[ADDR_W-1:0];
        mem_wdata_r <= {word_buf_r[23:0], in_data};
      end else begin
        mem_addr_r  <= mem_addr_r;
      end
    end else begin
      byte_cnt_r <= byte_cnt_r;
    end
  end

  assign in_ready   = in_ready_r;
  assign core_hold  = core_hold_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign load_error = load_error_r;
  assign checksum   = checksum_r;
  // Write strobe and done pulse must be suppressible by abort in their own cycle
  assign mem_we     = (state_r == WRITE) && !abort;
  assign load_done  = (state_r == DONE) && !abort;

endmodule
